// File: rtl/secded_pkg.sv
// Shared SEC-DED definitions: code geometry helpers and decode classification.
// Used by both the decoder and the matching encoder.
package secded_pkg;

  typedef enum logic [1:0] {
    CLEAN,
    SINGLE,
    DOUBLE
  } secded_class_e;

  // Smallest P with 2**P >= data_w + P + 1 (Hamming check-bit count).
  function automatic int secded_p_w(input int data_w);
    int p_w;
    p_w = 0;
    for (int p = 8; p >= 1; p--) begin
      if ((1 << p) >= data_w + p + 1) p_w = p;
    end
    return p_w;
  endfunction

  // Codeword position of data bit idx: the idx-th non-power-of-two position from 3 upward.
  function automatic int secded_pos(input int idx);
    int res;
    int cnt;
    res = 0;
    cnt = 0;
    for (int p = 3; p < 256; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/secded_syndrome_calc.sv
// Combinational syndrome and overall-parity generator for the SEC-DED code.
module secded_syndrome_calc
  import secded_pkg::*;
#(
  parameter int DATA_W = 28,
  parameter int P_W    = secded_p_w(DATA_W)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [P_W:0]      ecc_i,
  output logic [P_W-1:0]    syn_o,
  output logic              parity_o
);

  logic [P_W-1:0] pos_tbl [DATA_W];

  for (genvar i = 0; i < DATA_W; i++) begin : g_pos
    localparam logic [P_W-1:0] POS = P_W'(secded_pos(i));
    assign pos_tbl[i] = POS;
  end

  // Each set data bit contributes its codeword position to the syndrome.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    syn_o = ecc_i[P_W-1:0];
    for (int i = 0; i < DATA_W; i++) begin
      syn_o = syn_o ^ (pos_tbl[i] & {P_W{data_i[i]}});
    end
    parity_o = ^{data_i, ecc_i};
  end

endmodule

// File: rtl/secded_decode_pipe.sv
// Two-stage pipelined SEC-DED decoder with valid/ready flow control,
// saturating error counters and first-uncorrectable tag capture.
module secded_decode_pipe
  import secded_pkg::*;
#(
  parameter  int DATA_W = 28,
  parameter  int TAG_W  = 12,
  parameter  int CNT_W  = 16,
  localparam int P_W    = secded_p_w(DATA_W),
  localparam int ECC_W  = P_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ECC_W-1:0]  ecc_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              single_err_o,
  output logic              double_err_o,
  output logic [CNT_W-1:0]  corr_cnt_o,
  output logic [CNT_W-1:0]  uncorr_cnt_o,
  output logic              first_vld_o,
  output logic [TAG_W-1:0]  first_tag_o,
  input  logic              clr_i
);

  localparam logic [P_W-1:0] MAX_POS = P_W'(DATA_W + P_W);

  logic              s1_v_q, s2_v_q;
  logic [DATA_W-1:0] s1_data_q, s2_data_q;
  logic [TAG_W-1:0]  s1_tag_q, s2_tag_q;
  logic [P_W-1:0]    s1_syn_q;
  logic              s1_par_q;
  logic              s2_single_q, s2_double_q;

  logic [P_W-1:0]    calc_syn;
  logic              calc_par;
  logic              s1_adv, s2_adv, out_hs;
  secded_class_e     cls;
  logic [DATA_W-1:0] flip_mask, corr_data;

  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;
  logic              first_vld_q, first_vld_d;
  logic [TAG_W-1:0]  first_tag_q, first_tag_d;

  secded_syndrome_calc #(
    .DATA_W (DATA_W),
    .P_W    (P_W)
  ) u_syndrome (
    .data_i   (data_i),
    .ecc_i    (ecc_i),
    .syn_o    (calc_syn),
    .parity_o (calc_par)
  );

  // A stage moves when it is empty or its successor is moving; ready never depends on in_valid_i.
  assign s2_adv     = !s2_v_q || out_ready_i;
  assign s1_adv     = !s1_v_q || s2_adv;
  assign in_ready_o = s1_adv;
  assign out_hs     = s2_v_q && out_ready_i;

  for (genvar i = 0; i < DATA_W; i++) begin : g_mask
    localparam logic [P_W-1:0] POS = P_W'(secded_pos(i));
    assign flip_mask[i] = (s1_syn_q == POS);
  end

  // Out-of-range syndromes with odd parity are flagged rather than miscorrected.
  always_comb begin
    cls = CLEAN;
    if (s1_par_q) begin
      cls = (s1_syn_q > MAX_POS) ? DOUBLE : SINGLE;
    end else if (s1_syn_q != '0) begin
      cls = DOUBLE;
    end
    corr_data = s1_data_q;
    if (cls == SINGLE) corr_data = s1_data_q ^ flip_mask;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      s1_v_q      <= 1'b0;
      s1_data_q   <= '0;
      s1_tag_q    <= '0;
      s1_syn_q    <= '0;
      s1_par_q    <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_data_q   <= '0;
      s2_tag_q    <= '0;
      s2_single_q <= 1'b0;
      s2_double_q <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_v_q <= in_valid_i;
        if (in_valid_i) begin
          s1_data_q <= data_i;
          s1_tag_q  <= tag_i;
          s1_syn_q  <= calc_syn;
          s1_par_q  <= calc_par;
        end
      end
      if (s2_adv) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_data_q   <= corr_data;
          s2_tag_q    <= s1_tag_q;
          s2_single_q <= (cls == SINGLE);
          s2_double_q <= (cls == DOUBLE);
        end
      end
    end
  end

  // Clear applies before counting so a same-cycle error handshake survives the clear.
  always_comb begin
    corr_cnt_d   = clr_i ? '0 : corr_cnt_q;
    uncorr_cnt_d = clr_i ? '0 : uncorr_cnt_q;
    first_vld_d  = clr_i ? 1'b0 : first_vld_q;
    first_tag_d  = first_tag_q;
    if (out_hs && s2_single_q && (corr_cnt_d != '1)) corr_cnt_d = corr_cnt_d + CNT_W'(1);
    if (out_hs && s2_double_q) begin
      if (uncorr_cnt_d != '1) uncorr_cnt_d = uncorr_cnt_d + CNT_W'(1);
      if (!first_vld_d) begin
        first_vld_d = 1'b1;
        first_tag_d = s2_tag_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      first_vld_q  <= 1'b0;
      first_tag_q  <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      first_vld_q  <= first_vld_d;
      first_tag_q  <= first_tag_d;
    end
  end

  assign out_valid_o  = s2_v_q;
  assign data_o       = s2_data_q;
  assign tag_o        = s2_tag_q;
  assign single_err_o = s2_single_q;
  assign double_err_o = s2_double_q;
  assign corr_cnt_o   = corr_cnt_q;
  assign uncorr_cnt_o = uncorr_cnt_q;
  assign first_vld_o  = first_vld_q;
  assign first_tag_o  = first_tag_q;

endmodule

// File: tb/tb_secded_decode_pipe.sv
// Self-checking bench: randomized and directed words scored against a codeword-level model.
module tb_secded_decode_pipe;

  localparam int DATA_W = 28;
  localparam int ECC_W  = 7;
  localparam int TAG_W  = 12;
  localparam int CNT_W  = 4;
  localparam int N_POS  = 34;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_i, in_valid_i, out_ready_i, clr_i;
  logic              in_ready_o, out_valid_o, single_err_o, double_err_o, first_vld_o;
  logic [DATA_W-1:0] data_i, data_o;
  logic [ECC_W-1:0]  ecc_i;
  logic [TAG_W-1:0]  tag_i, tag_o, first_tag_o;
  logic [CNT_W-1:0]  corr_cnt_o, uncorr_cnt_o;

  always #5 clk = ~clk;

  secded_decode_pipe #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .data_i       (data_i),
    .ecc_i        (ecc_i),
    .tag_i        (tag_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .data_o       (data_o),
    .tag_o        (tag_o),
    .single_err_o (single_err_o),
    .double_err_o (double_err_o),
    .corr_cnt_o   (corr_cnt_o),
    .uncorr_cnt_o (uncorr_cnt_o),
    .first_vld_o  (first_vld_o),
    .first_tag_o  (first_tag_o),
    .clr_i        (clr_i)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    bit                single;
    bit                dbl;
    int                cyc;
  } exp_t;

  exp_t              exp_q[$];
  int                n_checks = 0;
  int                n_errors = 0;
  int                cyc = 0;
  int                last_lat = 0;
  bit                in_acc = 0;
  bit                rand_rdy = 0;
  int                m_corr = 0;
  int                m_uncorr = 0;
  bit                m_first_vld = 0;
  logic [TAG_W-1:0]  m_first_tag = '0;
  bit                held = 0;
  logic [DATA_W-1:0] held_data;
  logic [TAG_W-1:0]  held_tag;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Check bits from the code definition: check k is bit k of the XOR of set data positions.
  function automatic logic [ECC_W-1:0] model_encode(input logic [DATA_W-1:0] d);
    int syn = 0;
    int di = 0;
    logic [ECC_W-1:0] e;
    for (int pos = 1; pos <= N_POS; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (d[di]) syn = syn ^ pos;
        di++;
      end
    end
    e[5:0] = syn[5:0];
    e[6]   = ^{d, e[5:0]};
    return e;
  endfunction

  // Builds the full codeword, XORs the positions of its set bits and repairs it.
  function automatic exp_t model_decode(input logic [DATA_W-1:0] d, input logic [ECC_W-1:0] e,
                                        input logic [TAG_W-1:0] tag);
    bit   cw[N_POS+1];
    int   syn = 0;
    bit   par = e[6];
    int   di = 0;
    exp_t r;
    for (int pos = 1; pos <= N_POS; pos++) begin
      if ((pos & (pos - 1)) == 0) cw[pos] = e[$clog2(pos)];
      else begin
        cw[pos] = d[di];
        di++;
      end
      if (cw[pos]) syn = syn ^ pos;
      par = par ^ cw[pos];
    end
    r.data = d; r.tag = tag; r.single = 0; r.dbl = 0; r.cyc = 0;
    if (par && syn <= N_POS) begin
      r.single = 1;
      if (syn != 0) cw[syn] = !cw[syn];
      di = 0;
      for (int pos = 1; pos <= N_POS; pos++) begin
        if ((pos & (pos - 1)) != 0) begin
          r.data[di] = cw[pos];
          di++;
        end
      end
    end else if (syn != 0) begin
      r.dbl = 1;
    end
    return r;
  endfunction

  // kind: 0 clean, 1 one flipped bit, 2 two flipped bits, 3 garbage check bits.
  function automatic logic [DATA_W+ECC_W-1:0] make_word(input int kind);
    logic [DATA_W-1:0] d;
    logic [DATA_W+ECC_W-1:0] v;
    int b1, b2;
    d = DATA_W'($urandom);
    v = {model_encode(d), d};
    b1 = $urandom_range(0, 34);
    b2 = (b1 + $urandom_range(1, 34)) % 35;
    case (kind)
      1:       v[b1] = ~v[b1];
      2:       begin v[b1] = ~v[b1]; v[b2] = ~v[b2]; end
      3:       v[34:28] = 7'($urandom);
      default: ;
    endcase
    return v;
  endfunction

  task automatic monitor();
    exp_t e;
    cyc++;
    in_acc = 0;
    if (rst_i) begin
      exp_q.delete();
      m_corr = 0; m_uncorr = 0; m_first_vld = 0; held = 0;
      return;
    end
    if (held) begin
      check("hold_data", data_o, held_data);
      check("hold_tag", tag_o, held_tag);
    end
    check("corr_cnt", corr_cnt_o, m_corr);
    check("uncorr_cnt", uncorr_cnt_o, m_uncorr);
    check("first_vld", first_vld_o, m_first_vld);
    if (m_first_vld) check("first_tag", first_tag_o, m_first_tag);
    if (clr_i) begin
      m_corr = 0; m_uncorr = 0; m_first_vld = 0;
    end
    if (out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) check("out_unexpected", out_valid_o, 0);
      else begin
        e = exp_q.pop_front();
        check("out_data", data_o, e.data);
        check("out_tag", tag_o, e.tag);
        check("out_single", single_err_o, e.single);
        check("out_double", double_err_o, e.dbl);
        last_lat = cyc - e.cyc;
        if (e.single && m_corr < CNT_MAX) m_corr++;
        if (e.dbl) begin
          if (m_uncorr < CNT_MAX) m_uncorr++;
          if (!m_first_vld) begin
            m_first_vld = 1;
            m_first_tag = e.tag;
          end
        end
      end
    end
    held = out_valid_o && !out_ready_i;
    held_data = data_o;
    held_tag = tag_o;
    if (in_valid_i && in_ready_o) begin
      e = model_decode(data_i, ecc_i, tag_i);
      e.cyc = cyc;
      exp_q.push_back(e);
      in_acc = 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      out_ready_i = ($urandom_range(0, 3) != 0);
      clr_i = ($urandom_range(0, 40) == 0);
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic [ECC_W-1:0] e, input logic [TAG_W-1:0] t);
    bit acc = 0;
    in_valid_i = 1; data_i = d; ecc_i = e; tag_i = t;
    for (int n = 0; n < 300 && !acc; n++) begin
      cycle();
      acc = in_acc;
    end
    in_valid_i = 0;
    check("accept", acc, 1);
  endtask

  task automatic send_vec(input logic [DATA_W+ECC_W-1:0] v, input logic [TAG_W-1:0] t);
    send(v[DATA_W-1:0], v[DATA_W+ECC_W-1:DATA_W], t);
  endtask

  task automatic drain();
    int n = 0;
    out_ready_i = 1;
    while ((exp_q.size() != 0 || out_valid_o) && n < 200) begin
      cycle();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_clr();
    clr_i = 1;
    cycle();
    clr_i = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic [DATA_W+ECC_W-1:0] v, words[8];
    int idx, n;

    rst_i = 1; in_valid_i = 0; data_i = '0; ecc_i = '0; tag_i = '0; out_ready_i = 1; clr_i = 0;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_tag", tag_o, 0);
    check("rst_corr", corr_cnt_o, 0);
    check("rst_uncorr", uncorr_cnt_o, 0);
    check("rst_first_vld", first_vld_o, 0);

    d = 28'h0ABCDEF;
    send(d, model_encode(d), 12'h001);
    drain();
    check("clean_latency", last_lat, 2);
    check("clean_corr", corr_cnt_o, 0);

    send(d ^ 28'h20, model_encode(d), 12'h002);
    drain();
    check("single5_corr", corr_cnt_o, 1);

    for (int b = 0; b < DATA_W + ECC_W; b++) begin
      v = make_word(0);
      v[b] = ~v[b];
      send_vec(v, TAG_W'(b));
    end
    drain();

    pulse_clr();
    send(d ^ 28'h8000001, model_encode(d), 12'h5A5);
    drain();
    check("dbl_uncorr", uncorr_cnt_o, 1);
    check("dbl_first_vld", first_vld_o, 1);
    check("dbl_first_tag", first_tag_o, 12'h5A5);

    // Backpressure: consumer stalls for 5 cycles while 8 words stream in.
    for (int i = 0; i < 8; i++) words[i] = make_word(i % 3);
    out_ready_i = 0;
    idx = 0;
    in_valid_i = 1;
    {ecc_i, data_i} = words[0];
    tag_i = 12'h100;
    for (int c = 0; c < 200 && idx < 8; c++) begin
      cycle();
      if (in_acc) begin
        idx++;
        if (idx < 8) begin
          {ecc_i, data_i} = words[idx];
          tag_i = TAG_W'(12'h100 + idx);
        end else in_valid_i = 0;
      end
      if (c == 4) begin
        check("bp_accepted", idx, 2);
        check("bp_in_ready", in_ready_o, 0);
        out_ready_i = 1;
      end
    end
    in_valid_i = 0;
    drain();
    check("bp_all_sent", idx, 8);

    pulse_clr();
    for (int i = 0; i < 20; i++) send_vec(make_word(1), TAG_W'(i));
    drain();
    check("sat_corr", corr_cnt_o, CNT_MAX);

    send_vec(make_word(2), 12'h222);
    drain();
    send_vec(make_word(2), 12'h333);
    drain();
    check("log_keep_tag", first_tag_o, 12'h222);
    check("log_uncorr2", uncorr_cnt_o, 2);
    out_ready_i = 0;
    send_vec(make_word(2), 12'h444);
    n = 0;
    while (!out_valid_o && n < 20) begin
      cycle();
      n++;
    end
    check("clr_hs_valid", out_valid_o, 1);
    clr_i = 1;
    out_ready_i = 1;
    cycle();
    clr_i = 0;
    check("clr_hs_uncorr", uncorr_cnt_o, 1);
    check("clr_hs_first_vld", first_vld_o, 1);
    check("clr_hs_first_tag", first_tag_o, 12'h444);

    rand_rdy = 1;
    for (int i = 0; i < 400; i++) send_vec(make_word($urandom_range(0, 3)), TAG_W'($urandom));
    rand_rdy = 0;
    clr_i = 0;
    drain();

    // Asynchronous reset with both stages full.
    send_vec(make_word(1), 12'h0A1);
    send_vec(make_word(2), 12'h0A2);
    drain();
    out_ready_i = 0;
    send_vec(make_word(1), 12'h0B1);
    send_vec(make_word(0), 12'h0B2);
    check("pre_rst_valid", out_valid_o, 1);
    check("pre_rst_in_ready", in_ready_o, 0);
    #2 rst_i = 1;
    #1;
    check("arst_out_valid", out_valid_o, 0);
    check("arst_corr", corr_cnt_o, 0);
    check("arst_uncorr", uncorr_cnt_o, 0);
    check("arst_first_vld", first_vld_o, 0);
    check("arst_data", data_o, 0);
    check("arst_in_ready", in_ready_o, 1);
    cycle();
    cycle();
    rst_i = 0;
    out_ready_i = 1;
    d = 28'h1234567;
    send(d, model_encode(d), 12'h0C0);
    drain();
    check("post_rst_latency", last_lat, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
